// File: rtl/rgb_matrix_pkg.sv
// Shared types and helpers for the HUB75 scan driver: FSM states, pixel-pair
// word layout and width helpers.
package rgb_matrix_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    BLANK,
    LATCH,
    DISPLAY
  } scan_state_t;

  // Field order inside a pixel-pair word {R1,G1,B1,R2,G2,B2}; B2 sits at the LSBs.
  typedef enum int {
    FLD_B2 = 0,
    FLD_G2 = 1,
    FLD_R2 = 2,
    FLD_B1 = 3,
    FLD_G1 = 4,
    FLD_R1 = 5
  } pix_field_t;

  localparam int NUM_FIELDS = 6;

  // Default panel geometry: 32 columns, 8 scanned row pairs.
  localparam int COL_W = 5;
  localparam int ROW_W = 3;

  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int field_lsb(input pix_field_t f, input int color_bits);
    return int'(f) * color_bits;
  endfunction

endpackage

// File: rtl/rgb_matrix_col_shifter.sv
// Column shifter: steps through one row of pixel pairs, generating the panel
// shift clock and registering the colour bits of the active plane.
module rgb_matrix_col_shifter
  import rgb_matrix_pkg::*;
#(
  parameter int COLS       = 32,
  parameter int COLOR_BITS = 4,
  parameter int CLK_DIV    = 2,
  localparam int CW  = width_of(COLS),
  localparam int PW  = width_of(COLOR_BITS),
  localparam int FBW = NUM_FIELDS * COLOR_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shift_en,
  input  logic [PW-1:0]         plane,
  input  logic [FBW-1:0]        fb_rd_data,
  output logic [CW-1:0]         col,
  output logic                  clk_out,
  output logic                  shift_done,
  output logic [NUM_FIELDS-1:0] color
);

  localparam int STEP = 2 * CLK_DIV;
  localparam int KW   = width_of(STEP);

  logic [KW-1:0]         k_reg;
  logic [CW-1:0]         col_reg;
  logic [NUM_FIELDS-1:0] color_reg;
  logic [NUM_FIELDS-1:0] plane_bits;
  logic                  step_end;
  logic                  load_color;

  assign step_end   = shift_en && (k_reg == KW'(STEP - 1));
  // Read data for the address issued at k=0 is valid during k=1.
  assign load_color = shift_en && (k_reg == KW'(1));
  assign shift_done = step_end && (col_reg == CW'(COLS - 1));
  assign clk_out    = shift_en && (k_reg >= KW'(CLK_DIV));
  assign col        = col_reg;
  assign color      = color_reg;

  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
    logic [COLOR_BITS-1:0] chan;
    assign chan           = fb_rd_data[field_lsb(pix_field_t'(gi), COLOR_BITS) +: COLOR_BITS];
    assign plane_bits[gi] = chan[plane];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_reg   <= '0;
      col_reg <= '0;
    end else if (!shift_en) begin
      k_reg <= '0;
    end else if (step_end) begin
      k_reg   <= '0;
      col_reg <= shift_done ? '0 : col_reg + CW'(1);
    end else begin
      k_reg <= k_reg + KW'(1);
    end
  end

  // Colours change together with the rising shift clock and hold until the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      color_reg <= '0;
    end else if (load_color) begin
      color_reg <= plane_bits;
    end
  end

endmodule

// File: rtl/rgb_matrix_scan_driver.sv
// HUB75 scan driver: walks row pairs and BCM planes, shifting each plane out of
// the framebuffer, latching it and displaying it for a binary-weighted time.
module rgb_matrix_scan_driver
  import rgb_matrix_pkg::*;
#(
  parameter int COLS       = 1 << COL_W,
  parameter int ROW_PAIRS  = 1 << ROW_W,
  parameter int COLOR_BITS = 4,
  parameter int CLK_DIV    = 2,
  parameter int BASE_TICKS = 8,
  localparam int CW  = width_of(COLS),
  localparam int RW  = width_of(ROW_PAIRS),
  localparam int FBW = NUM_FIELDS * COLOR_BITS
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  output logic [RW+CW-1:0] fb_rd_addr,
  input  logic [FBW-1:0] fb_rd_data,
  output logic           r1,
  output logic           g1,
  output logic           b1,
  output logic           r2,
  output logic           g2,
  output logic           b2,
  output logic           addr_a,
  output logic           addr_b,
  output logic           addr_c,
  output logic           clk_out,
  output logic           lat,
  output logic           oe_n,
  output logic           frame_done
);

  localparam int PW = width_of(COLOR_BITS);
  localparam int DW = width_of(BASE_TICKS) + COLOR_BITS;

  scan_state_t           state_reg;
  scan_state_t           state_next;
  logic [RW-1:0]         row_reg;
  logic [RW-1:0]         addr_reg;
  logic [PW-1:0]         plane_reg;
  logic [DW-1:0]         disp_cnt_reg;
  logic [DW-1:0]         disp_len;
  logic                  frame_done_reg;
  logic                  shift_en;
  logic                  shift_done;
  logic                  disp_done;
  logic                  last_plane;
  logic                  last_row;
  logic                  frame_end;
  logic                  lat_c;
  logic                  oe_n_c;
  logic [CW-1:0]         col;
  logic [NUM_FIELDS-1:0] color;
  logic [2:0]            row_sel;

  rgb_matrix_col_shifter #(
    .COLS       (COLS),
    .COLOR_BITS (COLOR_BITS),
    .CLK_DIV    (CLK_DIV)
  ) u_col_shifter (
    .clk        (clk),
    .reset      (reset),
    .shift_en   (shift_en),
    .plane      (plane_reg),
    .fb_rd_data (fb_rd_data),
    .col        (col),
    .clk_out    (clk_out),
    .shift_done (shift_done),
    .color      (color)
  );

  // Plane p is shown for BASE_TICKS << p cycles.
  assign disp_len   = DW'(BASE_TICKS) << plane_reg;
  assign disp_done  = (state_reg == DISPLAY) && (disp_cnt_reg == disp_len - DW'(1));
  assign last_plane = (plane_reg == PW'(COLOR_BITS - 1));
  assign last_row   = (row_reg == RW'(ROW_PAIRS - 1));
  assign frame_end  = disp_done && last_plane && last_row;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // enable is only consulted in IDLE and at frame end, so frames are never torn.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable) state_next = SHIFT;
      SHIFT:   if (shift_done) state_next = BLANK;
      BLANK:   state_next = LATCH;
      LATCH:   state_next = DISPLAY;
      DISPLAY: if (disp_done) state_next = (frame_end && !enable) ? IDLE : SHIFT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shift_en = 1'b0;
    lat_c    = 1'b0;
    oe_n_c   = 1'b1;
    case (state_reg)
      SHIFT:   shift_en = 1'b1;
      LATCH:   lat_c    = 1'b1;
      DISPLAY: oe_n_c   = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_reg        <= '0;
      plane_reg      <= '0;
      disp_cnt_reg   <= '0;
      addr_reg       <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= frame_end;
      // Row select changes on LATCH entry, while the panel is blanked.
      if (state_reg == BLANK) begin
        addr_reg <= row_reg;
      end
      if (state_reg == DISPLAY) begin
        if (disp_done) begin
          disp_cnt_reg <= '0;
          if (last_plane) begin
            plane_reg <= '0;
            row_reg   <= last_row ? '0 : row_reg + RW'(1);
          end else begin
            plane_reg <= plane_reg + PW'(1);
          end
        end else begin
          disp_cnt_reg <= disp_cnt_reg + DW'(1);
        end
      end else begin
        disp_cnt_reg <= '0;
      end
    end
  end

  assign fb_rd_addr = {row_reg, col};
  assign row_sel    = 3'(addr_reg);
  assign addr_a     = row_sel[0];
  assign addr_b     = row_sel[1];
  assign addr_c     = row_sel[2];
  assign lat        = lat_c;
  assign oe_n       = oe_n_c;
  assign frame_done = frame_done_reg;
  assign r1         = color[FLD_R1];
  assign g1         = color[FLD_G1];
  assign b1         = color[FLD_B1];
  assign r2         = color[FLD_R2];
  assign g2         = color[FLD_G2];
  assign b2         = color[FLD_B2];

endmodule
